// File: rtl/hs32_lsu_pkg.sv
// Shared codes for the hs32 load/store sequencer: access sizes, fault codes, FSM states.
package hs32_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_TMO   = 2'b10;
    localparam logic [1:0] FLT_SIZE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/hs32_lsu_lane.sv
// Byte-lane steering: byte enables, replicated store data and extracted/extended load data.
module hs32_lsu_lane
    import hs32_lsu_pkg::*;
#(
    parameter  int unsigned DW = 32,
    localparam int unsigned NB = DW / 8,
    localparam int unsigned LB = $clog2(NB)
) (
    input  logic [LB-1:0] i_off,
    input  logic [1:0]    i_size,
    input  logic          i_sext,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_dtrm,
    output logic [NB-1:0] o_mbe_c,
    output logic [DW-1:0] o_mdtw_c,
    output logic [DW-1:0] o_rdata_c
);

    logic [DW-1:0] w_sh;

    // Right-justify the addressed lanes of the read word
    assign w_sh = i_dtrm >> {i_off, 3'b000};

    // Per-size enables, store replication and load extension
    always_comb begin
        o_mbe_c   = '0;
        o_mdtw_c  = i_wdata;
        o_rdata_c = w_sh;
        case (i_size)
            SZ_BYTE: begin
                o_mbe_c   = NB'(1) << i_off;
                o_mdtw_c  = {NB{i_wdata[7:0]}};
                o_rdata_c = {{(DW-8){i_sext & w_sh[7]}}, w_sh[7:0]};
            end
            SZ_HALF: begin
                o_mbe_c   = NB'(3) << i_off;
                o_mdtw_c  = {(NB/2){i_wdata[15:0]}};
                o_rdata_c = {{(DW-16){i_sext & w_sh[15]}}, w_sh[15:0]};
            end
            SZ_WORD: begin
                o_mbe_c   = '1;
                o_mdtw_c  = i_wdata;
                o_rdata_c = w_sh;
            end
            default: begin
                o_mbe_c   = '0;
                o_mdtw_c  = i_wdata;
                o_rdata_c = w_sh;
            end
        endcase
    end

endmodule

// File: rtl/hs32_lsu.sv
// Load/store sequencer between the execute FSM and the memory arbiter.
module hs32_lsu
    import hs32_lsu_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    output logic                rdy,
    input  logic                rw,
    input  logic [1:0]          size,
    input  logic                sext,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       wdata,
    output logic                done,
    output logic [DW-1:0]       rdata,
    output logic [1:0]          fault,
    output logic [AW-1:0]       maddr,
    output logic [DW-1:0]       mdtw,
    output logic [DW/8-1:0]     mbe,
    output logic                reqm,
    output logic                rw_mem,
    input  logic                rdym,
    input  logic [DW-1:0]       dtrm
);

    localparam int unsigned NB      = DW / 8;
    localparam int unsigned LB      = $clog2(NB);
    localparam int unsigned CW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TLAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          HAS_TMO = (TIMEOUT != 0);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rdy;
    logic            r_done;
    logic            r_reqm;
    logic            r_rw_mem;
    logic [1:0]      r_fault;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_rdata;
    logic [AW-1:0]   r_maddr;
    logic [DW-1:0]   r_mdtw;
    logic [NB-1:0]   r_mbe;
    logic [1:0]      r_size;
    logic            r_sext;
    logic [LB-1:0]   r_off;

    logic            w_take;
    logic            w_bad_size;
    logic            w_misal;
    logic            w_hs;
    logic            w_tmo;
    logic [LB-1:0]   w_lane_off;
    logic [1:0]      w_lane_size;
    logic [NB-1:0]   w_lane_mbe;
    logic [DW-1:0]   w_lane_mdtw;
    logic [DW-1:0]   w_lane_rdata;

    // Request acceptance, request checks, handshake and timeout detection
    assign w_take     = (r_state == ST_IDLE) && req;
    assign w_bad_size = (size == SZ_RSVD);
    assign w_misal    = ((size == SZ_HALF) && addr[0]) ||
                        ((size == SZ_WORD) && (addr[LB-1:0] != '0));
    assign w_hs       = (r_state == ST_REQ) && r_reqm && rdym;
    assign w_tmo      = HAS_TMO && (r_state == ST_REQ) && !w_hs && (r_cnt == CW'(TLAST));

    // Lane steering uses the live request while idle, the latched one afterwards
    assign w_lane_off  = (r_state == ST_IDLE) ? addr[LB-1:0] : r_off;
    assign w_lane_size = (r_state == ST_IDLE) ? size : r_size;

    hs32_lsu_lane #(.DW(DW)) u_lane (
        .i_off     (w_lane_off),
        .i_size    (w_lane_size),
        .i_sext    (r_sext),
        .i_wdata   (wdata),
        .i_dtrm    (dtrm),
        .o_mbe_c   (w_lane_mbe),
        .o_mdtw_c  (w_lane_mdtw),
        .o_rdata_c (w_lane_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_take) w_state_nxt = (w_bad_size || w_misal) ? ST_FIN : ST_REQ;
            ST_REQ:  if (w_hs || w_tmo) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake, status and timeout counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdy    <= 1'b1;
            r_done   <= 1'b0;
            r_reqm   <= 1'b0;
            r_rw_mem <= 1'b0;
            r_fault  <= FLT_OK;
            r_cnt    <= '0;
        end else begin
            r_rdy  <= (w_state_nxt == ST_IDLE);
            r_done <= (w_state_nxt == ST_FIN);
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        if (w_bad_size) begin
                            r_fault <= FLT_SIZE;
                        end else if (w_misal) begin
                            r_fault <= FLT_ALIGN;
                        end else begin
                            r_reqm   <= 1'b1;
                            r_rw_mem <= rw;
                            r_cnt    <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (w_hs) begin
                        r_reqm  <= 1'b0;
                        r_fault <= FLT_OK;
                    end else if (w_tmo) begin
                        r_reqm  <= 1'b0;
                        r_fault <= FLT_TMO;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-side address/data/enables and load data capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
            r_maddr <= '0;
            r_mdtw  <= '0;
            r_mbe   <= '0;
            r_size  <= SZ_BYTE;
            r_sext  <= 1'b0;
            r_off   <= '0;
        end else begin
            if (w_take) begin
                r_size <= size;
                r_sext <= sext;
                r_off  <= addr[LB-1:0];
                if (!w_bad_size && !w_misal) begin
                    r_maddr <= {addr[AW-1:LB], LB'(0)};
                    r_mbe   <= w_lane_mbe;
                    r_mdtw  <= w_lane_mdtw;
                end
            end
            if (w_hs && !r_rw_mem) r_rdata <= w_lane_rdata;
        end
    end

    assign rdy    = r_rdy;
    assign done   = r_done;
    assign rdata  = r_rdata;
    assign fault  = r_fault;
    assign maddr  = r_maddr;
    assign mdtw   = r_mdtw;
    assign mbe    = r_mbe;
    assign reqm   = r_reqm;
    assign rw_mem = r_rw_mem;

endmodule

// File: tb/tb_hs32_lsu.sv
// Directed bench for hs32_lsu (AW=DW=32, TIMEOUT=4).
module tb_hs32_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        rdy;
    logic        rw;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic [31:0] maddr;
    logic [31:0] mdtw;
    logic [3:0]  mbe;
    logic        reqm;
    logic        rw_mem;
    logic        rdym;
    logic [31:0] dtrm;

    int n_pass  = 0;
    int n_total = 0;

    hs32_lsu #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .rdy    (rdy),
        .rw     (rw),
        .size   (size),
        .sext   (sext),
        .addr   (addr),
        .wdata  (wdata),
        .done   (done),
        .rdata  (rdata),
        .fault  (fault),
        .maddr  (maddr),
        .mdtw   (mdtw),
        .mbe    (mbe),
        .reqm   (reqm),
        .rw_mem (rw_mem),
        .rdym   (rdym),
        .dtrm   (dtrm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then drop req
    task automatic issue(input logic i_rw, input logic [1:0] i_size, input logic i_sext,
                         input logic [31:0] i_addr, input logic [31:0] i_wdata);
        req   = 1'b1;
        rw    = i_rw;
        size  = i_size;
        sext  = i_sext;
        addr  = i_addr;
        wdata = i_wdata;
        step();
        req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; rw = 1'b0; size = 2'b00; sext = 1'b0;
        addr = '0; wdata = '0; rdym = 1'b0; dtrm = '0;
        step();
        step();
        chk("rst_rdy",   32'(rdy),    32'd1);
        chk("rst_done",  32'(done),   32'd0);
        chk("rst_reqm",  32'(reqm),   32'd0);
        chk("rst_rwmem", 32'(rw_mem), 32'd0);
        chk("rst_fault", 32'(fault),  32'd0);
        chk("rst_rdata", rdata,       32'h0);
        chk("rst_maddr", maddr,       32'h0);
        chk("rst_mbe",   32'(mbe),    32'h0);
        chk("rst_mdtw",  mdtw,        32'h0);
        reset = 1'b1;
        step();

        // 1: word load, rdym high in the first REQ cycle
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        chk("t1_reqm",  32'(reqm),   32'd1);
        chk("t1_rdy",   32'(rdy),    32'd0);
        chk("t1_done0", 32'(done),   32'd0);
        chk("t1_maddr", maddr,       32'h0000_0100);
        chk("t1_mbe",   32'(mbe),    32'hF);
        chk("t1_rwmem", 32'(rw_mem), 32'd0);
        rdym = 1'b1; dtrm = 32'hDEAD_BEEF;
        step();
        rdym = 1'b0;
        chk("t1_done",  32'(done),  32'd1);
        chk("t1_rdata", rdata,      32'hDEAD_BEEF);
        chk("t1_fault", 32'(fault), 32'd0);
        chk("t1_reqm0", 32'(reqm),  32'd0);
        step();
        chk("t1_done_drop", 32'(done), 32'd0);
        chk("t1_rdy_back",  32'(rdy),  32'd1);

        // 2: byte load at offset 3, sign- then zero-extended
        rdym = 1'b1; dtrm = 32'h8012_3456;
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        chk("t2_mbe", 32'(mbe), 32'h8);
        step();
        chk("t2_done_s",  32'(done), 32'd1);
        chk("t2_rdata_s", rdata,     32'hFFFF_FF80);
        step();
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        step();
        chk("t2_rdata_z", rdata, 32'h0000_0080);
        step();

        // Half load at offset 2, sign-extended
        dtrm = 32'h8001_5555;
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
        chk("t2h_mbe", 32'(mbe), 32'hC);
        step();
        chk("t2h_rdata", rdata, 32'hFFFF_8001);
        step();

        // 3: half store at offset 2; rdata must not move
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_1234);
        chk("t3_rwmem", 32'(rw_mem), 32'd1);
        chk("t3_maddr", maddr,       32'h0000_0100);
        chk("t3_mbe",   32'(mbe),    32'hC);
        chk("t3_mdtw",  mdtw,        32'h1234_1234);
        step();
        chk("t3_done",  32'(done), 32'd1);
        chk("t3_rdata", rdata,     32'hFFFF_8001);
        step();

        // Byte store at offset 1
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00AB);
        chk("t3b_mbe",  32'(mbe), 32'h2);
        chk("t3b_mdtw", mdtw,     32'hABAB_ABAB);
        step();
        step();
        rdym = 1'b0;

        // 4: misaligned word load and reserved size fault without a memory access
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
        chk("t4_reqm",  32'(reqm),  32'd0);
        chk("t4_done",  32'(done),  32'd1);
        chk("t4_fault", 32'(fault), 32'd1);
        chk("t4_maddr", maddr,      32'h0000_0100);
        step();
        chk("t4_done0", 32'(done), 32'd0);
        chk("t4_rdy",   32'(rdy),  32'd1);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0200, 32'h0);
        chk("t4s_reqm",  32'(reqm),  32'd0);
        chk("t4s_done",  32'(done),  32'd1);
        chk("t4s_fault", 32'(fault), 32'd3);
        step();
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0);
        chk("t4h_fault", 32'(fault), 32'd1);
        step();

        // 5: timeout after 4 REQ cycles, then a late rdym is ignored
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        chk("t5_reqm_c1", 32'(reqm), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("t5_reqm_c%0d", i), 32'(reqm), 32'd1);
            chk($sformatf("t5_done_c%0d", i), 32'(done), 32'd0);
        end
        step();
        chk("t5_done",  32'(done),  32'd1);
        chk("t5_fault", 32'(fault), 32'd2);
        chk("t5_reqm0", 32'(reqm),  32'd0);
        chk("t5_rdata", rdata,      32'hFFFF_8001);
        rdym = 1'b1; dtrm = 32'h5A5A_5A5A;
        step();
        chk("t5_late_done", 32'(done), 32'd0);
        chk("t5_late_reqm", 32'(reqm), 32'd0);
        step();
        chk("t5_late_done2", 32'(done), 32'd0);
        rdym = 1'b0;

        // rdym arriving in the 4th REQ cycle wins over the timeout
        dtrm = 32'hCAFE_F00D;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0);
        step();
        step();
        step();
        chk("t5b_reqm_c4", 32'(reqm), 32'd1);
        rdym = 1'b1;
        step();
        rdym = 1'b0;
        chk("t5b_done",  32'(done),  32'd1);
        chk("t5b_fault", 32'(fault), 32'd0);
        chk("t5b_rdata", rdata,      32'hCAFE_F00D);
        step();

        // 6: reset during REQ with rdym pending abandons the access
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        chk("t6_reqm", 32'(reqm), 32'd1);
        reset = 1'b0; rdym = 1'b1; dtrm = 32'h7777_7777;
        step();
        chk("t6_reqm0", 32'(reqm),  32'd0);
        chk("t6_rdy",   32'(rdy),   32'd1);
        chk("t6_done",  32'(done),  32'd0);
        chk("t6_rdata", rdata,      32'h0);
        reset = 1'b1; rdym = 1'b0;
        step();
        chk("t6_done_after", 32'(done), 32'd0);
        rdym = 1'b1; dtrm = 32'h1122_3344;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0);
        chk("t6n_maddr", maddr, 32'h0000_0404);
        step();
        rdym = 1'b0;
        chk("t6n_done",  32'(done),  32'd1);
        chk("t6n_rdata", rdata,      32'h1122_3344);
        chk("t6n_fault", 32'(fault), 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
